// File: rtl/axis_serial_fifo_pkg.sv
// Shared helpers for the width-down stream buffer: ceiling log2 and the
// width of the slice index register.
package axis_serial_fifo_pkg;

    // A slice index needs at least one bit, even for a single slice.
    localparam int SLICE_IDX_MIN_WIDTH = 1;

    // Ceiling log2 that is safe to use in constant expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Width of the slice index for a given number of slices.
    function automatic int idx_width(input int data_nb);
        return (clog2(data_nb) < SLICE_IDX_MIN_WIDTH) ? SLICE_IDX_MIN_WIDTH : clog2(data_nb);
    endfunction

endpackage

// File: rtl/fifo_simple.sv
// Single-clock FIFO with registered read data, occupancy count and
// empty/full flags (plus almost variants) derived from the registered count.
module fifo_simple #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  empty_a,
    output logic                  full,
    output logic                  full_a,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push,
    output logic [DATA_WIDTH-1:0] pop_data,
    input  logic                  pop
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_reg;
    logic [ADDR_WIDTH-1:0] rd_ptr_reg;
    logic [ADDR_WIDTH:0]   count_reg;
    logic [ADDR_WIDTH:0]   count_next;
    logic [DATA_WIDTH-1:0] pop_data_reg;
    logic                  push_eff;
    logic                  pop_eff;

    // Flags come from the registered count, so a word written into an empty
    // FIFO only becomes poppable one cycle later.
    assign empty   = (count_reg == '0);
    assign empty_a = (count_reg <= (ADDR_WIDTH+1)'(1));
    assign full    = (count_reg == (ADDR_WIDTH+1)'(DEPTH));
    assign full_a  = (count_reg >= (ADDR_WIDTH+1)'(DEPTH - 1));
    assign count   = count_reg;
    assign pop_data = pop_data_reg;

    // Guard both ends so misuse by a client cannot corrupt the pointers.
    assign push_eff = push & ~full;
    assign pop_eff  = pop & ~empty;

    // Occupancy is adjusted by one for each accepted push and pop.
    always_comb begin
        count_next = count_reg + (ADDR_WIDTH+1)'(push_eff) - (ADDR_WIDTH+1)'(pop_eff);
    end

    // Storage array: write-only here, no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers, count and the registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            pop_data_reg <= '0;
        end else begin
            count_reg <= count_next;
            if (push_eff) begin
                wr_ptr_reg <= wr_ptr_reg + ADDR_WIDTH'(1);
            end
            if (pop_eff) begin
                pop_data_reg <= mem[rd_ptr_reg];
                rd_ptr_reg   <= rd_ptr_reg + ADDR_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/axis_serial_fifo.sv
// Width-down stream buffer: wide words are sliced LSB-first into narrow
// words and queued in a FIFO drained through a pop/empty interface.
module axis_serial_fifo
    import axis_serial_fifo_pkg::*;
#(
    parameter int DATA_NB    = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_NB*DATA_WIDTH-1:0] up_data,
    input  logic                          up_valid,
    output logic                          up_ready,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         pop_data,
    output logic                          empty,
    output logic                          empty_a,
    output logic                          full,
    output logic                          full_a,
    output logic [ADDR_WIDTH:0]           count
);

    localparam int IDX_W = idx_width(DATA_NB);

    logic [DATA_NB*DATA_WIDTH-1:0] hold_reg;
    logic [DATA_NB*DATA_WIDTH-1:0] hold_next;
    logic                          loaded_reg;
    logic                          loaded_next;
    logic [IDX_W-1:0]              idx_reg;
    logic [IDX_W-1:0]              idx_next;
    logic [DATA_WIDTH-1:0]         slices [DATA_NB];
    logic [DATA_WIDTH-1:0]         ser_data;
    logic                          ser_valid;
    logic                          ser_ready;
    logic                          fire;
    logic                          last;
    logic                          fifo_full;

    // Break the held word into its narrow slices, slice 0 in the LSBs.
    for (genvar gi = 0; gi < DATA_NB; gi++) begin : g_slice
        assign slices[gi] = hold_reg[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    assign ser_valid = loaded_reg;
    assign ser_data  = slices[idx_reg];
    assign ser_ready = ~fifo_full;
    assign fire      = ser_valid & ser_ready;
    assign last      = (idx_reg == IDX_W'(DATA_NB - 1));

    // Accept a new word while idle, or in the same cycle the last slice
    // leaves, so consecutive wide words stream without a bubble.
    assign up_ready = ~loaded_reg | (fire & last);
    assign full     = fifo_full;

    // Serializer next state: load, finish, or advance to the next slice.
    always_comb begin
        hold_next   = hold_reg;
        loaded_next = loaded_reg;
        idx_next    = idx_reg;
        if (up_valid && up_ready) begin
            hold_next   = up_data;
            idx_next    = '0;
            loaded_next = 1'b1;
        end else if (fire && last) begin
            loaded_next = 1'b0;
            idx_next    = '0;
        end else if (fire) begin
            idx_next = idx_reg + IDX_W'(1);
        end
    end

    // Serializer control state; reset drops any held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            loaded_reg <= 1'b0;
            idx_reg    <= '0;
        end else begin
            loaded_reg <= loaded_next;
            idx_reg    <= idx_next;
        end
    end

    // Held data needs no reset: it is ignored while loaded_reg is low.
    always_ff @(posedge clk) begin
        hold_reg <= hold_next;
    end

    fifo_simple #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .count     (count),
        .empty     (empty),
        .empty_a   (empty_a),
        .full      (fifo_full),
        .full_a    (full_a),
        .push_data (ser_data),
        .push      (fire),
        .pop_data  (pop_data),
        .pop       (pop)
    );

endmodule

// File: tb/tb_axis_serial_fifo.sv
// Bench for axis_serial_fifo: directed wide words, scoreboard of expected
// narrow words, monitor comparing every effective pop.
module tb_axis_serial_fifo;

    localparam int NB = 4;
    localparam int DW = 8;
    localparam int AW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NB*DW-1:0] up_data = '0;
    logic            up_valid = 1'b0;
    logic            up_ready;
    logic            pop = 1'b0;
    logic [DW-1:0]   pop_data;
    logic            empty;
    logic            empty_a;
    logic            full;
    logic            full_a;
    logic [AW:0]     count;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q [$];
    int max_count;

    axis_serial_fifo #(
        .DATA_NB    (NB),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .up_data  (up_data),
        .up_valid (up_valid),
        .up_ready (up_ready),
        .pop      (pop),
        .pop_data (pop_data),
        .empty    (empty),
        .empty_a  (empty_a),
        .full     (full),
        .full_a   (full_a),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the expected narrow words of one wide word, LSB slice first.
    task automatic expect_word(input logic [NB*DW-1:0] w);
        logic [NB*DW-1:0] t;
        t = w;
        for (int i = 0; i < NB; i++) begin
            exp_q.push_back(t[i*DW +: DW]);
        end
    endtask

    // Monitor: a pop accepted at this edge delivers its word just after it.
    always @(posedge clk) begin
        if (!rst && pop && !empty) begin
            logic [DW-1:0] e;
            if (exp_q.size() == 0) begin
                #1;
                total++;
                bad++;
                $display("FAIL pop_unexpected actual=%0h required=none", pop_data);
            end else begin
                e = exp_q.pop_front();
                #1;
                total++;
                if (pop_data !== e) begin
                    bad++;
                    $display("FAIL pop_data actual=%0h required=%0h", pop_data, e);
                end else begin
                    $display("pop  data=%0h", pop_data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle.
        tick();
        tick();
        rst = 1'b0;
        check("rst_up_ready", up_ready, 1);
        check("rst_empty", empty, 1);
        check("rst_empty_a", empty_a, 1);
        check("rst_full", full, 0);
        check("rst_full_a", full_a, 0);
        check("rst_count", count, 0);
        check("rst_pop_data", pop_data, 0);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check("pop_empty_count", count, 0);
        check("pop_empty_data", pop_data, 0);

        // Single word, then continuous popping.
        expect_word(32'h44332211);
        up_data = 32'h44332211;
        up_valid = 1'b1;
        tick();
        up_valid = 1'b0;
        check("lat_t_count", count, 0);
        check("lat_t_empty", empty, 1);
        tick();
        check("lat_t1_count", count, 1);
        check("lat_t1_empty", empty, 0);
        pop = 1'b1;
        max_count = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (int'(count) > max_count) max_count = int'(count);
        end
        pop = 1'b0;
        check("single_peak_le4", (max_count <= 4) ? 1 : 0, 1);
        check("single_empty", empty, 1);
        check("single_q_drained", exp_q.size(), 0);

        // Back-to-back wide words with up_valid held and continuous pops.
        expect_word(32'hA3A2A1A0);
        expect_word(32'hB3B2B1B0);
        up_data = 32'hA3A2A1A0;
        up_valid = 1'b1;
        pop = 1'b1;
        tick();
        up_data = 32'hB3B2B1B0;
        check("b2b_ready_busy", up_ready, 0);
        tick();
        check("b2b_count_t1", count, 1);
        tick();
        check("b2b_ready_mid", up_ready, 0);
        tick();
        check("b2b_ready_last", up_ready, 1);
        tick();
        up_valid = 1'b0;
        for (int i = 4; i <= 8; i++) begin
            check($sformatf("b2b_count_t%0d", i), count, 1);
            tick();
        end
        check("b2b_count_end", count, 0);
        pop = 1'b0;
        check("b2b_q_drained", exp_q.size(), 0);

        // Fill the 4-deep FIFO and stall the serializer.
        expect_word(32'hC3C2C1C0);
        expect_word(32'hD3D2D1D0);
        up_data = 32'hC3C2C1C0;
        up_valid = 1'b1;
        tick();
        up_data = 32'hD3D2D1D0;
        tick();
        tick();
        check("fill_c2_full_a", full_a, 0);
        tick();
        check("fill_c3_count", count, 3);
        check("fill_c3_full_a", full_a, 1);
        check("fill_c3_full", full, 0);
        tick();
        up_valid = 1'b0;
        check("fill_c4_count", count, 4);
        check("fill_c4_full", full, 1);
        check("fill_up_ready", up_ready, 0);
        tick();
        tick();
        check("stall_count", count, 4);
        check("stall_up_ready", up_ready, 0);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check("pop1_count", count, 3);
        check("pop1_full", full, 0);
        check("pop1_full_a", full_a, 1);
        tick();
        check("refill_count", count, 4);
        check("refill_full", full, 1);
        tick();
        check("refill_once", count, 4);

        // Drain everything.
        pop = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        pop = 1'b0;
        check("drain_count", count, 0);
        check("drain_q", exp_q.size(), 0);

        // Repeated fill/drain across pointer wrap.
        for (int r = 0; r < 3; r++) begin
            logic [31:0] w;
            w = 32'h10203040 + 32'h01010101 * r;
            expect_word(w);
            up_data = w;
            up_valid = 1'b1;
            tick();
            up_valid = 1'b0;
            for (int i = 0; i < 5; i++) tick();
            check($sformatf("wrap%0d_full", r), count, 4);
            pop = 1'b1;
            for (int i = 0; i < 6; i++) tick();
            pop = 1'b0;
            check($sformatf("wrap%0d_empty", r), count, 0);
        end

        // Simultaneous push and pop with two words queued.
        expect_word(32'hF3F2F1F0);
        up_data = 32'hF3F2F1F0;
        up_valid = 1'b1;
        tick();
        up_valid = 1'b0;
        tick();
        check("sim_count1", count, 1);
        tick();
        check("sim_count2", count, 2);
        pop = 1'b1;
        tick();
        check("sim_pushpop_a", count, 2);
        tick();
        check("sim_pushpop_b", count, 2);
        tick();
        tick();
        pop = 1'b0;
        check("sim_end", count, 0);
        check("sim_q", exp_q.size(), 0);

        // Reset in the middle of serialization with three words queued.
        expect_word(32'h67666564);
        up_data = 32'h67666564;
        up_valid = 1'b1;
        tick();
        up_valid = 1'b0;
        tick();
        tick();
        tick();
        check("prerst_count", count, 3);
        rst = 1'b1;
        up_valid = 1'b1;
        up_data = 32'h87868584;
        pop = 1'b1;
        tick();
        exp_q.delete();
        rst = 1'b0;
        pop = 1'b0;
        check("midrst_count", count, 0);
        check("midrst_empty", empty, 1);
        check("midrst_up_ready", up_ready, 1);
        check("midrst_pop_data", pop_data, 0);
        expect_word(32'h87868584);
        tick();
        up_valid = 1'b0;
        pop = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("restart_count", count, 0);
        check("restart_q", exp_q.size(), 0);
        tick();
        check("pop_empty_hold", pop_data, 32'h87);
        pop = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
